// File: rtl/ecdsa_modaddsub.sv
// Multi-cycle modular adder/subtractor: (A +/- B) mod M
// on a W-bit carry-chained slice adder, two passes of N/W slices.
module ecdsa_modaddsub #(
  parameter int N = 381,
  parameter int W = 127
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         subtract,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_m,
  output logic [N-1:0] result,
  output logic         busy,
  output logic         done
);

  localparam int C  = N / W;
  localparam int CW = (C > 1) ? $clog2(C) : 1;
  localparam logic [CW-1:0] LAST = CW'(C - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD1,
    ADD2,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  m_q, m_d;
  logic [N-1:0]  s_q, s_d;
  logic [N-1:0]  t_q, t_d;
  logic [N-1:0]  res_q, res_d;
  logic          sub_q, sub_d;
  logic          cy_q, cy_d;
  logic          c1_q, c1_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [W-1:0]  x, y;
  logic [W:0]    sum;
  logic [N-1:0]  s_rot, t_nxt;
  logic          last;

  // Slice adder: pass 1 adds A + B', pass 2 adds S + M'
  always_comb begin
    x = a_q[W-1:0];
    y = sub_q ? ~b_q[W-1:0] : b_q[W-1:0];
    if (state_q == ADD2) begin
      x = s_q[W-1:0];
      y = sub_q ? m_q[W-1:0] : ~m_q[W-1:0];
    end
    sum   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cy_q};
    s_rot = {s_q[W-1:0], s_q[N-1:W]};
    t_nxt = {sum[W-1:0], t_q[N-1:W]};
    last  = (cnt_q == LAST);
  end

  // Next-state and datapath update; S rotates in pass 2 so it survives
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    s_d     = s_q;
    t_d     = t_q;
    res_d   = res_q;
    sub_d   = sub_q;
    cy_d    = cy_q;
    c1_d    = c1_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = in_a;
          b_d     = in_b;
          m_d     = in_m;
          sub_d   = subtract;
          cy_d    = subtract;
          cnt_d   = '0;
          state_d = ADD1;
        end
      end
      ADD1: begin
        a_d   = a_q >> W;
        b_d   = b_q >> W;
        s_d   = {sum[W-1:0], s_q[N-1:W]};
        cy_d  = sum[W];
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          c1_d    = sum[W];
          cy_d    = ~sub_q;
          cnt_d   = '0;
          state_d = ADD2;
        end
      end
      ADD2: begin
        s_d   = s_rot;
        m_d   = m_q >> W;
        t_d   = t_nxt;
        cy_d  = sum[W];
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          if (sub_q)
            res_d = c1_q ? s_rot : t_nxt;
          else
            res_d = (c1_q | sum[W]) ? t_nxt : s_rot;
          cy_d    = 1'b0;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      s_q     <= '0;
      t_q     <= '0;
      res_q   <= '0;
      sub_q   <= 1'b0;
      cy_q    <= 1'b0;
      c1_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      s_q     <= s_d;
      t_q     <= t_d;
      res_q   <= res_d;
      sub_q   <= sub_d;
      cy_q    <= cy_d;
      c1_q    <= c1_d;
      cnt_q   <= cnt_d;
    end
  end

  assign result = res_q;
  assign busy   = (state_q == ADD1) || (state_q == ADD2);
  assign done   = (state_q == DONE);

endmodule

// File: tb/tb_ecdsa_modaddsub.sv
// Bench for ecdsa_modaddsub: fixed vectors, random ops
// against a modular-arithmetic model, protocol and reset cases.
module tb_ecdsa_modaddsub;

  localparam int N = 381;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] m;
    logic         sub;
    logic [N-1:0] exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         subtract;
  logic [N-1:0] in_a, in_b, in_m;
  logic [N-1:0] result;
  logic         busy, done;

  int total = 0;
  int bad   = 0;

  ecdsa_modaddsub dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .subtract (subtract),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_m     (in_m),
    .result   (result),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [N-1:0] got,
                     input logic [N-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [N-1:0] rnd();
    logic [383:0] v;
    for (int i = 0; i < 12; i++) v[i*32 +: 32] = $urandom;
    return v[N-1:0];
  endfunction

  // Reference: plain modular arithmetic on N+1 bit values
  function automatic logic [N-1:0] model(input logic [N-1:0] a,
      input logic [N-1:0] b, input logic [N-1:0] m, input logic sub);
    logic [N:0] r;
    if (!sub) begin
      r = {1'b0, a} + {1'b0, b};
      if (r >= {1'b0, m}) r = r - {1'b0, m};
    end else if (a >= b) begin
      r = {1'b0, a} - {1'b0, b};
    end else begin
      r = {1'b0, a} + {1'b0, m} - {1'b0, b};
    end
    return r[N-1:0];
  endfunction

  function automatic vec_t mk(input logic [N-1:0] a, input logic [N-1:0] b,
      input logic [N-1:0] m, input logic sub, input logic [N-1:0] exp);
    vec_t v;
    v.a = a; v.b = b; v.m = m; v.sub = sub; v.exp = exp;
    return v;
  endfunction

  // Issue one op; operand inputs are scrambled right after the start cycle
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
      input logic [N-1:0] m, input logic sub,
      output logic [N-1:0] res, output int lat, output bit bz_ok);
    @(negedge clk);
    in_a = a; in_b = b; in_m = m; subtract = sub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_a = rnd(); in_b = rnd(); in_m = rnd(); subtract = ~sub;
    lat = 0;
    bz_ok = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (done) begin
        lat = c;
        if (busy) bz_ok = 1'b0;
        break;
      end
      if (!busy) bz_ok = 1'b0;
    end
    res = result;
  endtask

  task automatic op_chk(input string nm, input logic [N-1:0] a,
      input logic [N-1:0] b, input logic [N-1:0] m, input logic sub,
      input logic [N-1:0] exp);
    logic [N-1:0] res;
    int lat;
    bit bz;
    do_op(a, b, m, sub, res, lat, bz);
    chk({nm, "_res"}, res, exp);
    chk({nm, "_lat"}, N'(lat), N'(7));
    chk({nm, "_busy"}, N'(bz), N'(1));
    @(posedge clk); #1;
    chk({nm, "_pulse"}, N'(done), N'(0));
  endtask

  initial begin
    vec_t tbl[9];
    logic [N-1:0] p, one, m, a, b, res, r1;
    logic sub;
    int lat, ndone, dcyc;
    bit bz;

    p   = 381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;
    one = 1;
    tbl[0] = mk(50, 40, 97, 0, 90);
    tbl[1] = mk(50, 60, 97, 0, 13);
    tbl[2] = mk(96, 1, 97, 0, 0);
    tbl[3] = mk(20, 10, 97, 1, 10);
    tbl[4] = mk(10, 20, 97, 1, 87);
    tbl[5] = mk(33, 33, 97, 1, 0);
    tbl[6] = mk((one << 127) - one, 1, p, 0, one << 127);
    tbl[7] = mk(p - one, 1, p, 0, 0);
    tbl[8] = mk(0, 1, p, 1, p - one);

    reset = 1'b1; start = 1'b0; subtract = 1'b0;
    in_a = '0; in_b = '0; in_m = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result, 0);
    chk("rst_busy", N'(busy), 0);
    chk("rst_done", N'(done), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 9; i++)
      op_chk($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].m,
             tbl[i].sub, tbl[i].exp);

    for (int i = 0; i < 40; i++) begin
      case (i % 4)
        0: m = p;
        1: m = N'($urandom_range(1, 1000));
        default: m = rnd();
      endcase
      if (m == 0) m = 1;
      a = rnd() % m;
      b = rnd() % m;
      if (i % 8 == 3) b = a;
      sub = 1'($urandom_range(0, 1));
      op_chk($sformatf("rnd%0d", i), a, b, m, sub, model(a, b, m, sub));
    end

    // Second start during busy is ignored; one done pulse only
    @(negedge clk);
    in_a = 50; in_b = 60; in_m = 97; subtract = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    in_a = 5; in_b = 6; in_m = 97; subtract = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; dcyc = 0; r1 = '0;
    for (int c = 2; c <= 7; c++) begin
      if (c > 2) begin @(posedge clk); #1; end
      if (done) begin ndone++; dcyc = c; r1 = result; end
    end
    chk("prot_ndone", N'(ndone), 1);
    chk("prot_cyc", N'(dcyc), 7);
    chk("prot_res", r1, 13);
    @(posedge clk); #1;
    chk("prot_pulse", N'(done), 0);
    do_op(20, 30, 97, 1'b1, res, lat, bz);
    chk("b2b_res", res, 87);
    chk("b2b_lat", N'(lat), 7);

    // Reset in cycle 4 aborts the op at once
    @(negedge clk);
    in_a = 50; in_b = 40; in_m = 97; subtract = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    chk("abort_busy", N'(busy), 0);
    chk("abort_done", N'(done), 0);
    chk("abort_res", result, 0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort_nodone", N'(ndone), 0);
    op_chk("after_rst", 50, 40, 97, 1'b0, 90);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
